booth_multiplier: RTL and testbench
===================================

Name: booth_multiplier

Overview:
- Signed two's-complement multiplier using radix-4 (modified) Booth recoding.
- Multiplies two WIDTH-bit operands into a full-precision 2*WIDTH-bit product.
- Output is registered: one clock of latency, with a valid flag travelling alongside the data.
- Used as a drop-in arithmetic leaf wherever a small signed product is needed.

Parameters:
WIDTH  6  operand width in bits; must be even and >= 4; product width is 2*WIDTH

Ports:
clk        input   1          rising-edge clock
rst        input   1          synchronous reset, active-high
in_valid   input   1          in1/in2 carry a valid operand pair this cycle
in1        input   WIDTH      multiplicand, signed two's complement
in2        input   WIDTH      multiplier, signed two's complement (Booth-recoded operand)
out_valid  output  1          out holds the product of a valid pair
out        output  2*WIDTH    signed product in1*in2, two's complement

Behaviour:
- Reset and clocking:
  - One clock domain.
  - rst is sampled on the rising clk edge only (synchronous).
  - While rst=1 at an edge: out <= 0, out_valid <= 0.
  - Reset asserted mid-stream discards any product not yet registered.
  - First valid result can appear on the edge after the first non-reset edge with in_valid=1.
- Recoding:
  - in2 is extended with an implicit bit in2[-1]=0.
  - Split into WIDTH/2 overlapping triplets {in2[2k+1], in2[2k], in2[2k-1]}, k = 0..WIDTH/2-1.
  - Triplet to digit: 000,111 -> 0; 001,010 -> +1; 011 -> +2; 100 -> -2; 101,110 -> -1.
- Partial products:
  - PP_k = digit_k * in1, sign-extended to 2*WIDTH bits, then shifted left by 2k.
  - +2 / -2 use in1<<1 computed at WIDTH+1 bits, so in1 = -2^(WIDTH-1) does not overflow.
  - Negation is two's complement: invert plus +1. The +1 may be folded into the adder tree.
- Sum:
  - Sum of all PP_k, modulo 2^(2*WIDTH).
  - Combinational from in1/in2; no multi-cycle iteration.
- Registering and latency:
  - At each non-reset rising edge: out <= sum, out_valid <= in_valid. Latency is exactly 1 cycle.
  - out is updated every cycle regardless of in_valid, so it tracks the inputs one cycle later.
  - out_valid qualifies the value in out.
- Range:
  - Exact for all operand pairs, including both operands = -2^(WIDTH-1).
  - For WIDTH=6: -32 * -32 = +1024 = 0x400, which fits in the 12-bit signed range.
  - No saturation and no overflow flag, since the product always fits in 2*WIDTH bits.
- No internal state beyond the output registers.
- Back-to-back valid inputs are accepted every cycle; no backpressure.

Test Plan:
- Reset: rst=1 for 2 edges with arbitrary inputs -> out=0x000, out_valid=0. Release rst -> outputs follow inputs one edge later.
- Basic signs (WIDTH=6), one edge after applying each pair:
  - 5*3 -> 0x00F
  - -5*3 -> 0xFF1
  - 5*-3 -> 0xFF1
  - -5*-3 -> 0x00F
  - 0*-17 -> 0x000
- Extremes:
  - -32*-32 -> 0x400
  - -32*31 -> 0xC20 (-992)
  - 31*31 -> 0x3C1 (961)
  - -31*-32 -> 0x3E0 (992)
- Booth digit coverage:
  - in2 = 0b011011 (27), in1 = 7 -> 189 = 0x0BD
  - in2 = 0b100100 (-28), in1 = -7 -> 196 = 0x0C4
- Exhaustive: all in1 in [-32,31] x in2 in [-32,31], one pair per cycle with in_valid=1 -> every out equals the 12-bit truncation of the integer product one cycle later; zero mismatches.
- Pipelining/valid: alternate in_valid 1/0 on consecutive pairs; assert rst in the middle of the stream -> out_valid mirrors in_valid delayed by 1. The cycle after rst, out=0 and out_valid=0; the next product appears 1 cycle after rst deasserts.

Source files
------------

// File: rtl/booth_multiplier.sv
// Signed radix-4 Booth multiplier with a single registered output stage.
// The product is combinational from in1/in2 and lands in out one clock later, qualified by out_valid.
module booth_multiplier #(
    parameter int unsigned WIDTH = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH-1:0]   in2,
    output logic               out_valid,
    output logic [2*WIDTH-1:0] out
);

    localparam int unsigned NumPp = WIDTH / 2;
    localparam int unsigned PW    = 2 * WIDTH;

    typedef enum logic [2:0] {
        DigZero,
        DigPos1,
        DigPos2,
        DigNeg1,
        DigNeg2
    } booth_digit_e;

    logic [WIDTH:0]   in2_ext;
    logic [WIDTH:0]   in1_x1;
    logic [WIDTH:0]   in1_x2;
    booth_digit_e     digit   [NumPp];
    logic [WIDTH:0]   mag     [NumPp];
    logic             neg     [NumPp];
    logic [PW-1:0]    pp      [NumPp];
    logic [PW-1:0]    out_d;
    logic [PW-1:0]    out_q;
    logic             valid_q;

    // Implicit in2[-1] = 0 lives at bit 0 of the extended multiplier.
    assign in2_ext = {in2, 1'b0};
    // WIDTH+1 bits so that 2 * -2^(WIDTH-1) is still representable.
    assign in1_x1  = {in1[WIDTH-1], in1};
    assign in1_x2  = {in1, 1'b0};

    always_comb begin
        for (int k = 0; k < NumPp; k++) begin
            unique case (in2_ext[2*k +: 3])
                3'b001, 3'b010: digit[k] = DigPos1;
                3'b011:         digit[k] = DigPos2;
                3'b100:         digit[k] = DigNeg2;
                3'b101, 3'b110: digit[k] = DigNeg1;
                default:        digit[k] = DigZero;
            endcase
        end
    end

    always_comb begin
        for (int k = 0; k < NumPp; k++) begin
            mag[k] = '0;
            neg[k] = 1'b0;
            unique case (digit[k])
                DigPos1: mag[k] = in1_x1;
                DigPos2: mag[k] = in1_x2;
                DigNeg1: begin
                    mag[k] = ~in1_x1;
                    neg[k] = 1'b1;
                end
                DigNeg2: begin
                    mag[k] = ~in1_x2;
                    neg[k] = 1'b1;
                end
                default: mag[k] = '0;
            endcase
        end
    end

    // Sign-extend each one's-complement term and align it to its digit weight.
    always_comb begin
        for (int k = 0; k < NumPp; k++) begin
            pp[k] = {{(PW - WIDTH - 1){mag[k][WIDTH]}}, mag[k]} << (2 * k);
        end
    end

    // The +1 of every negated term is folded into the same sum at the digit's weight.
    always_comb begin
        out_d = '0;
        for (int k = 0; k < NumPp; k++) begin
            out_d = out_d + pp[k] + (PW'(neg[k]) << (2 * k));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= in_valid;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// Scoreboard bench for booth_multiplier (WIDTH=6): stimulus pushes expected results,
// a separate monitor pops and compares one registered result per clock.
module tb_booth_multiplier;

    localparam int unsigned W = 6;

    typedef struct packed {
        logic        v;
        logic [11:0] p;
        logic [31:0] id;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  in1;
    logic [W-1:0]  in2;
    logic          out_valid;
    logic [11:0]   out;

    exp_t          sb_q[$];
    int            checks = 0;
    int            errors = 0;
    int            next_id = 0;

    booth_multiplier #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out       (out)
    );

    always #5 clk = ~clk;

    task automatic apply(input logic r, input logic v, input int a, input int b,
                         input logic [11:0] exp_p);
        exp_t e;
        rst      = r;
        in_valid = v;
        in1      = W'(a);
        in2      = W'(b);
        e.v  = r ? 1'b0 : v;
        e.p  = r ? 12'h000 : exp_p;
        e.id = 32'(next_id);
        next_id++;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: each edge registers exactly one expected result.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                checks++;
                if (out !== e.p || out_valid !== e.v) begin
                    errors++;
                    $display("FAIL vec%0d: out=%h out_valid=%b, required out=%h out_valid=%b",
                             e.id, out, out_valid, e.p, e.v);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    int          da [11] = '{5, -5, 5, -5, 0, -32, -32, 31, -31, 7, -7};
    int          db [11] = '{3, 3, -3, -3, -17, -32, 31, 31, -32, 27, -28};
    logic [11:0] dx [11] = '{12'h00F, 12'hFF1, 12'hFF1, 12'h00F, 12'h000, 12'h400,
                             12'hC20, 12'h3C1, 12'h3E0, 12'h0BD, 12'h0C4};

    initial begin
        int prod;
        int budget;
        rst = 1'b1; in_valid = 1'b0; in1 = '0; in2 = '0;
        #1;
        // Reset with arbitrary live inputs must hold outputs at zero.
        apply(1'b1, 1'b1, 13, -9, 12'h000);
        apply(1'b1, 1'b1, -21, 17, 12'h000);

        for (int i = 0; i < 11; i++) apply(1'b0, 1'b1, da[i], db[i], dx[i]);

        for (int a = -32; a < 32; a++) begin
            for (int b = -32; b < 32; b++) begin
                prod = a * b;
                apply(1'b0, 1'b1, a, b, 12'(prod));
            end
        end

        // Alternating valid with a reset pulse in the middle of the stream.
        for (int i = 0; i < 10; i++) begin
            prod = (i + 3) * (-(i + 1));
            apply(i == 5, (i % 2) == 0, i + 3, -(i + 1), 12'(prod));
        end
        apply(1'b0, 1'b0, 0, 0, 12'h000);

        budget = 0;
        while (sb_q.size() != 0 && budget < 8) begin
            @(posedge clk);
            #3;
            budget++;
        end
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results never observed, required 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
